// File: rtl/port_rv_fifo.sv
// port_rv_fifo: ready/valid first-word-fall-through FIFO placed behind an
// input port bundle. Flags are decoded from the registered count, so neither
// flag depends combinationally on in_valid or out_ready.
module port_rv_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      count
);

  localparam logic [AW:0] CntFull = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_wr_ptr_d;
  logic [AW-1:0]    w_rd_ptr_d;
  logic [AW:0]      w_count_d;

  // Handshake flags and head-of-queue data from registered state only.
  always_comb begin
    in_ready  = rst_n && (r_count != CntFull);
    out_valid = rst_n && (r_count != '0);
    out_data  = r_mem[r_rd_ptr];
    count     = r_count;
    w_push    = in_valid && in_ready;
    w_pop     = out_valid && out_ready;
  end

  // Next pointer and occupancy; pointers wrap for free since DEPTH is a power of two.
  always_comb begin
    w_wr_ptr_d = r_wr_ptr;
    w_rd_ptr_d = r_rd_ptr;
    w_count_d  = r_count;
    if (w_push) begin
      w_wr_ptr_d = r_wr_ptr + 1'b1;
    end
    if (w_pop) begin
      w_rd_ptr_d = r_rd_ptr + 1'b1;
    end
    if (w_push && !w_pop) begin
      w_count_d = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_count_d = r_count - 1'b1;
    end
  end

  // Pointer and count registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_d;
      r_rd_ptr <= w_rd_ptr_d;
      r_count  <= w_count_d;
    end
  end

  // Storage array; contents are not reset, a push is masked during reset by in_ready.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_port_rv_fifo.sv
// Directed self-checking bench for port_rv_fifo (WIDTH=8, DEPTH=4).
module tb_port_rv_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;

  int n_chk;
  int n_err;

  port_rv_fifo #(
    .WIDTH(8),
    .DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle before driving or sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h99;
    out_ready = 1'b0;

    // Reset held with an offered word
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    step();
    chk("rst_count_a", count, 0);
    step();
    chk("rst_count_b", count, 0);
    chk("rst_in_ready_b", in_ready, 0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_count", count, 0);

    // Single word latency
    in_data  = 8'hA5;
    in_valid = 1'b1;
    chk("single_no_bypass", out_valid, 0);
    step();
    in_valid = 1'b0;
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 8'hA5);
    chk("single_count", count, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_pop_count", count, 0);
    chk("single_pop_valid", out_valid, 0);

    // Fill, overflow attempt, drain in order
    for (int i = 1; i <= 4; i++) begin
      in_data  = 8'(i);
      in_valid = 1'b1;
      step();
    end
    chk("fill_count", count, 4);
    chk("fill_in_ready", in_ready, 0);
    in_data = 8'h05;
    step();
    in_valid = 1'b0;
    chk("overflow_count", count, 4);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, i);
      step();
    end
    out_ready = 1'b0;
    chk("drain_empty_valid", out_valid, 0);
    chk("drain_empty_count", count, 0);

    // Full with simultaneous offer: pop only, push lands next cycle
    for (int i = 0; i < 4; i++) begin
      in_data  = 8'h31 + 8'(i);
      in_valid = 1'b1;
      step();
    end
    chk("full2_count", count, 4);
    in_data   = 8'h55;
    out_ready = 1'b1;
    chk("full2_head", out_data, 8'h31);
    step();
    out_ready = 1'b0;
    chk("full2_pop_only", count, 3);
    chk("full2_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("full2_refill", count, 4);
    out_ready = 1'b1;
    chk("full2_d0", out_data, 8'h32);
    step();
    chk("full2_d1", out_data, 8'h33);
    step();
    chk("full2_d2", out_data, 8'h34);
    step();
    chk("full2_d3", out_data, 8'h55);
    step();
    out_ready = 1'b0;
    chk("full2_empty", count, 0);

    // Steady stream across pointer wraps
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'h10 + 8'(i);
      if (i > 0) begin
        chk("stream_data", out_data, 8'h10 + i - 1);
      end
      step();
      chk("stream_count", count, 1);
    end
    in_valid = 1'b0;
    chk("stream_last", out_data, 8'h23);
    step();
    out_ready = 1'b0;
    chk("stream_empty", count, 0);

    // Reset mid-operation with push and pop presented
    for (int i = 0; i < 3; i++) begin
      in_data  = 8'h61 + 8'(i);
      in_valid = 1'b1;
      step();
    end
    chk("midrst_pre_count", count, 3);
    rst_n     = 1'b0;
    in_data   = 8'h66;
    out_ready = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    step();
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_valid", out_valid, 0);
    in_data  = 8'h77;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("postrst_data", out_data, 8'h77);
    chk("postrst_valid", out_valid, 1);
    chk("postrst_count", count, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/port_rv_fifo.md
Name: port_rv_fifo

Overview:
- Ready/valid buffering stage placed directly downstream of a module's 8-bit input port bundle.
- Accepts words on the input side and stores up to DEPTH of them in a first-word-fall-through queue.
- Presents the stored words in order to the consuming logic.
- Decouples producer and consumer timing; exposes occupancy for debug and test.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, number of storage entries; must be a power of two, at least 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_data  input  WIDTH  word offered by the upstream side.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a word this cycle.
- out_data  output  WIDTH  word at the head of the queue.
- out_valid  output  1  out_data holds a stored word.
- out_ready  input  1  downstream consumes the head word this cycle.
- count  output  AW+1  number of stored words, 0..DEPTH.

Behaviour:
- Reset:
  - When rst_n is low at a rising clk edge: wr_ptr=0, rd_ptr=0, count=0.
  - Storage contents are not reset.
  - While rst_n is low, in_ready=0 and out_valid=0 (combinationally masked).
  - After reset releases: in_ready=1, out_valid=0, count=0.
- Definitions:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - Any other combination has no effect on state.
- Flags:
  - in_ready = rst_n && (count != DEPTH).
  - out_valid = rst_n && (count != 0).
  - Both are decoded from registered count, so there is no combinational path from in_valid or out_ready to either flag.
- out_data:
  - Equals mem[rd_ptr] combinationally from registered state (first-word fall-through).
  - Value is don't-care while out_valid=0.
- Push: writes in_data to mem[wr_ptr] and increments wr_ptr modulo DEPTH.
- Pop: increments rd_ptr modulo DEPTH.
- count update:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
- Latency:
  - A word pushed into an empty FIFO appears on out_data with out_valid=1 in the next cycle.
  - There is no same-cycle bypass.
- Full (count=DEPTH):
  - in_ready=0, so in_valid is ignored.
  - A pop in that cycle makes in_ready=1 in the next cycle; a full FIFO never accepts a word in the same cycle it pops.
- Empty (count=0):
  - out_valid=0, so out_ready is ignored.
  - A simultaneous push is accepted and count becomes 1.
- Simultaneous push and pop with 0<count<DEPTH:
  - Both pointers advance and count holds.
  - Write and read slots differ, so there is no hazard.
- Wrap-around: pointers wrap from DEPTH-1 to 0 silently; ordering is preserved across the wrap.
- Handshake rules (upstream and downstream obligations):
  - in_data must stay stable while in_valid=1 and in_ready=0.
  - The FIFO holds out_data stable while out_valid=1 and out_ready=0.
- Reset mid-operation:
  - Synchronous rst_n low discards all stored words.
  - count=0 on the following edge.
  - A push or pop presented in the reset cycle is not performed.
- Never overflows or underflows; count never leaves 0..DEPTH.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release -> in_ready=1, out_valid=0, count=0; with rst_n=0, in_valid=1 -> in_ready=0 and count stays 0.
- Single word latency: push 0xA5 into an empty FIFO at edge N -> out_valid=1, out_data=0xA5, count=1 after edge N; pop at edge N+1 -> count=0, out_valid=0.
- Fill and order: out_ready=0, push 0x01,0x02,0x03,0x04 -> count=4, in_ready=0; a 5th word 0x05 is ignored; drain -> outputs 0x01..0x04 in order, then out_valid=0.
- Full with simultaneous offer: at count=4, in_valid=1 (0x55) and out_ready=1 -> pop only, count=3; next cycle 0x55 is accepted, count=4.
- Steady stream with wrap: in_valid=1 and out_ready=1 for 20 cycles, data 0x10..0x23 -> after the first word, count stays at 1; outputs match inputs in order across 5 pointer wraps.
- Reset mid-operation: with count=3, assert rst_n=0 for 1 cycle alongside push and pop -> count=0, out_valid=0 next cycle; a subsequent push of 0x77 reads back 0x77 first.
